uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rr_pick.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 121 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and sizing helpers for the uart tx scheduler
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_CLKS_PER_BIT = 17;
    localparam int DEF_GAP_CLKS     = 2;

    // One full frame (start + 8 data + stop + slack bit) plus a small margin.
    function automatic int timeout_clks(input int clks_per_bit);
        return 11 * clks_per_bit + 16;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker, search starts just above last_grant
module uart_rr_pick #(
    parameter int NUM_REQ = uart_pkg::DEF_NUM_REQ,
    parameter int IDW     = uart_pkg::id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     winner,
    output logic               valid
);

    logic [IDW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(last_grant) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - arbitrates byte requesters onto one uart_tx with done watchdog and inter-byte gap
module uart_tx_scheduler #(
    parameter int  NUM_REQ      = uart_pkg::DEF_NUM_REQ,
    parameter int  CLKS_PER_BIT = uart_pkg::DEF_CLKS_PER_BIT,
    parameter int  GAP_CLKS     = uart_pkg::DEF_GAP_CLKS,
    parameter int  TIMEOUT_CLKS = uart_pkg::timeout_clks(CLKS_PER_BIT),
    localparam int IDW          = uart_pkg::id_width(NUM_REQ)
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_DV,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic [IDW-1:0]       o_Grant_Id,
    output logic                 o_Timeout
);

    import uart_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam sched_state_t  AFTER_TX = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
    localparam logic          BUSY_AFTER_TX = (GAP_CLKS > 0);

    sched_state_t   state;
    logic [CW-1:0]  wd_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [IDW-1:0] last_grant;

    logic [IDW-1:0] pick_id;
    logic           pick_valid;
    logic [7:0]     pick_byte;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req        (i_Req_DV),
        .last_grant (last_grant),
        .winner     (pick_id),
        .valid      (pick_valid)
    );

    always_comb begin
        pick_byte = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDW'(k) == pick_id) begin
                pick_byte = i_Req_Byte[8*k +: 8];
            end
        end
    end

    // Ack, start and timeout are single-cycle pulses: cleared every clock unless re-asserted below.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state      <= ST_IDLE;
            o_Req_Ack  <= '0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= 8'h00;
            o_Busy     <= 1'b0;
            o_Grant_Id <= '0;
            o_Timeout  <= 1'b0;
            wd_cnt     <= '0;
            gap_cnt    <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
        end else begin
            o_Req_Ack <= '0;
            o_Tx_DV   <= 1'b0;
            o_Timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Hold off while the serializer still reports activity from an earlier frame.
                    if (pick_valid && !i_Tx_Active) begin
                        o_Req_Ack  <= NUM_REQ'(1) << pick_id;
                        o_Tx_DV    <= 1'b1;
                        o_Tx_Byte  <= pick_byte;
                        o_Grant_Id <= pick_id;
                        last_grant <= pick_id;
                        wd_cnt     <= '0;
                        o_Busy     <= 1'b1;
                        state      <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        gap_cnt <= GAP_LOAD;
                        o_Busy  <= BUSY_AFTER_TX;
                        state   <= AFTER_TX;
                    end else if (wd_cnt == WD_LAST) begin
                        o_Timeout <= 1'b1;
                        gap_cnt   <= GAP_LOAD;
                        o_Busy    <= BUSY_AFTER_TX;
                        state     <= AFTER_TX;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        o_Busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    o_Busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int GAP_CLKS = 2;
    localparam int TIMEOUT  = 203;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   i_Req_DV;
    logic [31:0]  i_Req_Byte;
    logic [3:0]   o_Req_Ack;
    logic         o_Tx_DV;
    logic [7:0]   o_Tx_Byte;
    logic         i_Tx_Active;
    logic         i_Tx_Done;
    logic         o_Busy;
    logic [1:0]   o_Grant_Id;
    logic         o_Timeout;

    typedef struct {
        int         id;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   dv_count = 0;
    int   align_err = 0;

    uart_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .CLKS_PER_BIT (17),
        .GAP_CLKS     (GAP_CLKS)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_DV    (i_Req_DV),
        .i_Req_Byte  (i_Req_Byte),
        .o_Req_Ack   (o_Req_Ack),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done),
        .o_Busy      (o_Busy),
        .o_Grant_Id  (o_Grant_Id),
        .o_Timeout   (o_Timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_Tx_DV !== (o_Req_Ack != 4'b0)) align_err++;
            if ($countones(o_Req_Ack) > 1) align_err++;
            if (o_Tx_DV) dv_count++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] b);
        exp_t e;
        e.id = id;
        e.b  = b;
        sb.push_back(e);
    endtask

    task automatic wait_dv(input string tag, output int n);
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_Tx_DV && n < 400);
        if (!o_Tx_DV) begin
            check_val({tag, "_dv_seen"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check_val({tag, "_unexpected_dv"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_grant"}, 32'(o_Grant_Id), e.id);
            check_val({tag, "_ack"}, 32'(o_Req_Ack), 32'(1) << e.id);
            check_val({tag, "_byte"}, 32'(o_Tx_Byte), 32'(e.b));
        end
    endtask

    task automatic pulse_done();
        i_Tx_Done = 1'b1;
        @(negedge clk);
        i_Tx_Done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_Req_DV = '0;
        i_Tx_Done = 1'b0;
        i_Tx_Active = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int d0;
        logic seen;

        rst = 1'b1;
        i_Req_DV = '0;
        i_Req_Byte = '0;
        i_Tx_Done = 1'b0;
        i_Tx_Active = 1'b0;
        @(negedge clk);
        check_val("rst_busy", 32'(o_Busy), 0);
        check_val("rst_dv", 32'(o_Tx_DV), 0);
        check_val("rst_ack", 32'(o_Req_Ack), 0);
        check_val("rst_byte", 32'(o_Tx_Byte), 0);
        check_val("rst_grant", 32'(o_Grant_Id), 0);
        check_val("rst_timeout", 32'(o_Timeout), 0);
        @(negedge clk);
        rst = 1'b0;

        // single request, then two gap cycles
        i_Req_Byte = 32'h0000_00A5;
        i_Req_DV = 4'b0001;
        push_exp(0, 8'hA5);
        wait_dv("single", n);
        check_val("single_latency", n, 1);
        i_Req_DV = '0;
        check_val("single_busy", 32'(o_Busy), 1);
        repeat (3) @(negedge clk);
        pulse_done();
        check_val("single_gap1", 32'(o_Busy), 1);
        @(negedge clk);
        check_val("single_gap2", 32'(o_Busy), 1);
        @(negedge clk);
        check_val("single_idle", 32'(o_Busy), 0);
        check_val("single_byte_hold", 32'(o_Tx_Byte), 32'hA5);

        // contention from reset: 0,1,2,3,0
        do_reset();
        i_Req_Byte = 32'h1312_1110;
        i_Req_DV = 4'b1111;
        push_exp(0, 8'h10);
        push_exp(1, 8'h11);
        push_exp(2, 8'h12);
        push_exp(3, 8'h13);
        push_exp(0, 8'h10);
        wait_dv("cont0", n);
        for (int i = 1; i < 5; i++) begin
            repeat (2) @(negedge clk);
            pulse_done();
            wait_dv($sformatf("cont%0d", i), n);
            check_val("cont_spacing", n, GAP_CLKS + 1);
        end
        i_Req_DV = '0;
        pulse_done();
        repeat (3) @(negedge clk);

        // wrap: last_grant=3 after reset, requests on 1 and 3
        do_reset();
        i_Req_Byte = 32'hD3C2_B1A0;
        i_Req_DV = 4'b1010;
        push_exp(1, 8'hB1);
        push_exp(3, 8'hD3);
        wait_dv("wrap_a", n);
        pulse_done();
        wait_dv("wrap_b", n);
        i_Req_DV = '0;
        pulse_done();
        repeat (3) @(negedge clk);

        // watchdog expiry
        i_Req_Byte = 32'h005A_0000;
        i_Req_DV = 4'b0100;
        push_exp(2, 8'h5A);
        wait_dv("tmo", n);
        i_Req_DV = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_Timeout && n < 300);
        check_val("tmo_delay", n, TIMEOUT);
        check_val("tmo_gap1", 32'(o_Busy), 1);
        @(negedge clk);
        check_val("tmo_width", 32'(o_Timeout), 0);
        check_val("tmo_gap2", 32'(o_Busy), 1);
        @(negedge clk);
        check_val("tmo_idle", 32'(o_Busy), 0);

        // done exactly on the expiry edge
        i_Req_Byte = 32'h005A_00C3;
        i_Req_DV = 4'b0001;
        push_exp(0, 8'hC3);
        wait_dv("coinc", n);
        i_Req_DV = '0;
        seen = 1'b0;
        repeat (TIMEOUT - 1) begin
            @(negedge clk);
            if (o_Timeout) seen = 1'b1;
        end
        pulse_done();
        check_val("coinc_no_tmo", 32'(o_Timeout), 0);
        check_val("coinc_early_tmo", 32'(seen), 0);
        check_val("coinc_gap", 32'(o_Busy), 1);
        @(negedge clk);
        check_val("coinc_no_tmo_late", 32'(o_Timeout), 0);
        @(negedge clk);

        // done while idle is ignored
        repeat (2) @(negedge clk);
        d0 = dv_count;
        pulse_done();
        seen = o_Busy;
        repeat (3) begin
            @(negedge clk);
            if (o_Busy) seen = 1'b1;
        end
        check_val("idle_done_busy", 32'(seen), 0);
        check_val("idle_done_dv", dv_count, d0);

        // tx_active high in idle blocks the start
        i_Tx_Active = 1'b1;
        i_Req_Byte = 32'h0000_0066;
        i_Req_DV = 4'b0001;
        push_exp(0, 8'h66);
        d0 = dv_count;
        repeat (5) @(negedge clk);
        check_val("active_hold_dv", dv_count, d0);
        check_val("active_hold_busy", 32'(o_Busy), 0);
        i_Tx_Active = 1'b0;
        wait_dv("active_release", n);
        check_val("active_release_latency", n, 1);
        i_Req_DV = '0;
        pulse_done();
        repeat (3) @(negedge clk);

        // reset in WAIT_DONE
        i_Req_Byte = 32'h0000_7700;
        i_Req_DV = 4'b0010;
        push_exp(1, 8'h77);
        wait_dv("mid", n);
        i_Req_DV = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(o_Busy), 0);
        check_val("mid_rst_dv", 32'(o_Tx_DV), 0);
        check_val("mid_rst_ack", 32'(o_Req_Ack), 0);
        check_val("mid_rst_byte", 32'(o_Tx_Byte), 0);
        check_val("mid_rst_grant", 32'(o_Grant_Id), 0);
        check_val("mid_rst_timeout", 32'(o_Timeout), 0);
        @(negedge clk);
        rst = 1'b0;
        d0 = dv_count;
        repeat (10) @(negedge clk);
        check_val("mid_no_reissue", dv_count, d0);
        i_Req_Byte = 32'h4400_0033;
        i_Req_DV = 4'b1001;
        push_exp(0, 8'h33);
        wait_dv("post_rst", n);
        i_Req_DV = '0;
        pulse_done();
        repeat (4) @(negedge clk);

        check_val("sb_empty", sb.size(), 0);
        check_val("ack_dv_align", align_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
